// File: rtl/dat_mem_mover.sv
// Block COPY / FILL initiator for the 8-bit data memory port.
// Every output is a registered decode of the next state, so there is no combinational path from start to any output.
module dat_mem_mover #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] src_ptr, src_ptr_d;
  logic [ADDR_W-1:0] dst_ptr, dst_ptr_d;
  logic [ADDR_W-1:0] rem_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              wr_en_d, busy_d, done_d;

  // Next-state and pointer update
  always_comb begin
    state_d    = state;
    src_ptr_d  = src_ptr;
    dst_ptr_d  = dst_ptr;
    rem_d      = remaining;
    buf_d      = buf_q;
    fill_val_d = fill_val_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            src_ptr_d  = src;
            dst_ptr_d  = dst;
            rem_d      = len;
            fill_val_d = fill_val;
            state_d    = op ? S_FILL : S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        buf_d   = mem_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        src_ptr_d = src_ptr + ADDR_W'(1);
        dst_ptr_d = dst_ptr + ADDR_W'(1);
        rem_d     = remaining - ADDR_W'(1);
        state_d   = (remaining == ADDR_W'(1)) ? S_DONE : S_RD;
      end
      S_FILL: begin
        dst_ptr_d = dst_ptr + ADDR_W'(1);
        rem_d     = remaining - ADDR_W'(1);
        state_d   = (remaining == ADDR_W'(1)) ? S_DONE : S_FILL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port decode of the upcoming state; idle port lines are held at zero
  always_comb begin
    addr_d  = '0;
    wdata_d = '0;
    wr_en_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_RD: begin
        addr_d = src_ptr_d;
        busy_d = 1'b1;
      end
      S_WR: begin
        addr_d  = dst_ptr_d;
        wdata_d = buf_d;
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_FILL: begin
        addr_d  = dst_ptr_d;
        wdata_d = fill_val_d;
        wr_en_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      buf_q      <= '0;
      fill_val_q <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr_en  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      src_ptr    <= src_ptr_d;
      dst_ptr    <= dst_ptr_d;
      remaining  <= rem_d;
      buf_q      <= buf_d;
      fill_val_q <= fill_val_d;
      mem_addr   <= addr_d;
      mem_wdata  <= wdata_d;
      mem_wr_en  <= wr_en_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
